data_mem_controller: RTL and testbench

- Sequences RV32IM loads and stores from the MEM stage onto a word-wide, byte-enabled, variable-latency data memory using a REQ/ACK handshake.
- Does byte-lane steering for stores, and extraction plus sign/zero extension for loads, using ADDRESS[1:0].
- Stalls the pipeline through BUSYWAIT.
- Detects misaligned accesses, illegal FUNCTION3 values and memory timeouts, and reports them as faults.

---
 rtl/data_mem_controller.sv | 201 ++++++++++++++++++++
 tb/tb_data_mem_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_controller.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_controller
// Description : MEM-stage load/store sequencer for an RV32IM pipeline. It
//               drives a word-wide, byte-enabled, variable-latency data memory
//               through a REQ/ACK handshake. It steers store bytes onto lanes,
//               extracts and extends load data, and stalls the pipeline through
//               BUSYWAIT. Misaligned accesses, illegal FUNCTION3 codes and
//               memory timeouts are reported as faults.
// Ports       : CLK, RESET (async, active-high)
//               MEM_READ/MEM_WRITE/FUNCTION3/ADDRESS/DATA2 - pipeline request
//               READ_DATA/BUSYWAIT/MISALIGNED/ACCESS_FAULT - pipeline response
//               MEM_REQ/MEM_WE/MEM_ADDR/MEM_BE/MEM_WDATA   - memory request
//               MEM_RDATA/MEM_ACK                          - memory response
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_controller #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNCTION3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] DATA2,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        MISALIGNED,
    output logic        ACCESS_FAULT,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [29:0] MEM_ADDR,
    output logic [3:0]  MEM_BE,
    output logic [31:0] MEM_WDATA,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_ACK
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    // Counter value on which the last permitted ACCESS cycle is spent.
    localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [31:0]      r_read_data;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [29:0]      r_mem_addr;
    logic [3:0]       r_mem_be;
    logic [31:0]      r_mem_wdata;
    logic [CNT_W-1:0] r_cnt;
    logic             r_misaligned;
    logic             r_access_fault;
    logic [2:0]       r_f3;
    logic [1:0]       r_off;

    logic             w_req;
    logic             w_illegal;
    logic             w_misal;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;

    assign w_req = MEM_READ | MEM_WRITE;

    // A store wins when both request lines are raised, so legality is
    // judged against the store encoding in that case.
    always_comb begin
        w_illegal = 1'b0;
        if (MEM_WRITE) begin
            w_illegal = !(FUNCTION3 == 3'b000 || FUNCTION3 == 3'b001 || FUNCTION3 == 3'b010);
        end else begin
            w_illegal = (FUNCTION3 == 3'b011 || FUNCTION3 == 3'b110 || FUNCTION3 == 3'b111);
        end
    end

    // FUNCTION3[1:0] encodes the size for both signed and unsigned forms.
    assign w_misal = ((FUNCTION3[1:0] == 2'b01) && ADDRESS[0]) ||
                     ((FUNCTION3[1:0] == 2'b10) && (ADDRESS[1:0] != 2'b00));

    // Store lane steering; loads always fetch the whole word.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = DATA2;
        if (MEM_WRITE) begin
            case (FUNCTION3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << ADDRESS[1:0];
                    w_wdata = {4{DATA2[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << {ADDRESS[1], 1'b0};
                    w_wdata = {2{DATA2[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = DATA2;
                end
            endcase
        end
    end

    // Load extraction uses the offset and width captured at issue time.
    always_comb begin
        w_byte = MEM_RDATA[8*r_off +: 8];
        w_half = r_off[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
        case (r_f3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = MEM_RDATA;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state        <= c_IDLE;
            r_read_data    <= '0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_be       <= '0;
            r_mem_wdata    <= '0;
            r_cnt          <= '0;
            r_misaligned   <= 1'b0;
            r_access_fault <= 1'b0;
            r_f3           <= '0;
            r_off          <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_req) begin
                        if (w_illegal) begin
                            r_access_fault <= 1'b1;
                            r_state        <= c_DONE;
                        end else if (w_misal) begin
                            r_misaligned   <= 1'b1;
                            r_state        <= c_DONE;
                        end else begin
                            r_mem_addr  <= ADDRESS[31:2];
                            r_mem_be    <= w_be;
                            r_mem_we    <= MEM_WRITE;
                            r_mem_wdata <= w_wdata;
                            r_f3        <= FUNCTION3;
                            r_off       <= ADDRESS[1:0];
                            r_cnt       <= '0;
                            r_mem_req   <= 1'b1;
                            r_state     <= c_ACCESS;
                        end
                    end
                end
                c_ACCESS: begin
                    // An ACK in the final permitted cycle still completes
                    // the access normally.
                    if (MEM_ACK) begin
                        if (!r_mem_we) begin
                            r_read_data <= w_load;
                        end
                        r_mem_req <= 1'b0;
                        r_state   <= c_DONE;
                    end else if (r_cnt == c_TMO_LAST) begin
                        r_access_fault <= 1'b1;
                        r_mem_req      <= 1'b0;
                        r_state        <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_DONE: begin
                    // The same instruction is still presented here, so
                    // request inputs are deliberately not examined.
                    r_misaligned   <= 1'b0;
                    r_access_fault <= 1'b0;
                    r_state        <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign BUSYWAIT     = ((r_state == c_IDLE) && w_req) || (r_state == c_ACCESS);
    assign READ_DATA    = r_read_data;
    assign MISALIGNED   = r_misaligned;
    assign ACCESS_FAULT = r_access_fault;
    assign MEM_REQ      = r_mem_req;
    assign MEM_WE       = r_mem_we;
    assign MEM_ADDR     = r_mem_addr;
    assign MEM_BE       = r_mem_be;
    assign MEM_WDATA    = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_controller
// Description : Self-checking bench for data_mem_controller. A table of
//               load/store vectors with expected results is replayed against
//               a small ACK-after-N-cycles memory responder; expectations are
//               queued at issue and compared when the access reaches DONE.
//               Hand-written sequences cover reset, stray ACKs and reset
//               during an access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_controller;

    logic        CLK;
    logic        RESET;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [2:0]  FUNCTION3;
    logic [31:0] ADDRESS;
    logic [31:0] DATA2;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT;
    logic        MISALIGNED;
    logic        ACCESS_FAULT;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [29:0] MEM_ADDR;
    logic [3:0]  MEM_BE;
    logic [31:0] MEM_WDATA;
    logic [31:0] MEM_RDATA;
    logic        MEM_ACK;

    data_mem_controller #(
        .CNT_W   (8),
        .TIMEOUT (4)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .MEM_READ     (MEM_READ),
        .MEM_WRITE    (MEM_WRITE),
        .FUNCTION3    (FUNCTION3),
        .ADDRESS      (ADDRESS),
        .DATA2        (DATA2),
        .READ_DATA    (READ_DATA),
        .BUSYWAIT     (BUSYWAIT),
        .MISALIGNED   (MISALIGNED),
        .ACCESS_FAULT (ACCESS_FAULT),
        .MEM_REQ      (MEM_REQ),
        .MEM_WE       (MEM_WE),
        .MEM_ADDR     (MEM_ADDR),
        .MEM_BE       (MEM_BE),
        .MEM_WDATA    (MEM_WDATA),
        .MEM_RDATA    (MEM_RDATA),
        .MEM_ACK      (MEM_ACK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // lat = ACCESS cycle in which memory acks (0 = never ack).
    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] d2;
        logic [31:0] rdata;
        int          lat;
        int          exp_busy;
        int          exp_req;
        logic        exp_mis;
        logic        exp_af;
        logic [31:0] exp_rd;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
    } vec_t;

    int   checks;
    int   errors;
    vec_t sb[$];
    vec_t tbl[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] d2,
                                input logic [31:0] rdata, input int lat,
                                input int eb, input int er, input logic em, input logic ea,
                                input logic [31:0] erd, input logic [3:0] ebe,
                                input logic [31:0] ewd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.d2 = d2; v.rdata = rdata;
        v.lat = lat; v.exp_busy = eb; v.exp_req = er; v.exp_mis = em; v.exp_af = ea;
        v.exp_rd = erd; v.exp_be = ebe; v.exp_wd = ewd;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        vec_t        e;
        int          busy;
        int          req;
        int          cyc;
        bit          done;
        logic [29:0] c_addr;
        logic [3:0]  c_be;
        logic [31:0] c_wd;
        logic        c_we;
        logic        c_mis;
        logic        c_af;
        logic [31:0] c_rd;
        busy = 0; req = 0; cyc = 0; done = 0;
        c_addr = '0; c_be = '0; c_wd = '0; c_we = 1'b0;
        c_mis = 1'b0; c_af = 1'b0; c_rd = '0;
        @(negedge CLK);
        MEM_READ  = v.rd;
        MEM_WRITE = v.wr;
        FUNCTION3 = v.f3;
        ADDRESS   = v.addr;
        DATA2     = v.d2;
        sb.push_back(v);
        while (!done && cyc < 300) begin
            #1;
            if (BUSYWAIT) busy++;
            if (MEM_REQ) begin
                req++;
                if (req == 1) begin
                    c_addr = MEM_ADDR; c_be = MEM_BE; c_wd = MEM_WDATA; c_we = MEM_WE;
                end
                if (req == v.lat) begin
                    MEM_ACK   = 1'b1;
                    MEM_RDATA = v.rdata;
                end
            end
            if (!BUSYWAIT) begin
                c_mis = MISALIGNED;
                c_af  = ACCESS_FAULT;
                c_rd  = READ_DATA;
                done  = 1;
                MEM_READ  = 1'b0;
                MEM_WRITE = 1'b0;
            end else begin
                @(negedge CLK);
                MEM_ACK   = 1'b0;
                MEM_RDATA = 32'hDEAD_BEEF;
                cyc++;
            end
        end
        e = sb.pop_front();
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL vec%0d done: no DONE cycle within 300 cycles", idx);
            MEM_READ  = 1'b0;
            MEM_WRITE = 1'b0;
        end
        chk($sformatf("vec%0d busy_cycles", idx), busy, e.exp_busy);
        chk($sformatf("vec%0d req_cycles", idx), req, e.exp_req);
        chk($sformatf("vec%0d misaligned", idx), {31'd0, c_mis}, {31'd0, e.exp_mis});
        chk($sformatf("vec%0d access_fault", idx), {31'd0, c_af}, {31'd0, e.exp_af});
        chk($sformatf("vec%0d read_data", idx), c_rd, e.exp_rd);
        if (e.exp_req > 0) begin
            chk($sformatf("vec%0d mem_addr", idx), {2'b00, c_addr}, {2'b00, e.addr[31:2]});
            chk($sformatf("vec%0d mem_be", idx), {28'd0, c_be}, {28'd0, e.exp_be});
            chk($sformatf("vec%0d mem_we", idx), {31'd0, c_we}, {31'd0, e.wr});
            if (e.wr) chk($sformatf("vec%0d mem_wdata", idx), c_wd, e.exp_wd);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RESET = 1'b1;
        MEM_READ = 1'b0; MEM_WRITE = 1'b0; FUNCTION3 = 3'b000;
        ADDRESS = '0; DATA2 = '0; MEM_RDATA = 32'hDEAD_BEEF; MEM_ACK = 1'b0;

        //          rd wr f3      addr          d2            rdata         lat busy req mis af  read_data     be       wdata
        tbl[0]  = mk(0, 1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0,        2, 3, 2, 0, 0, 32'h0000_0000, 4'b1000, 32'hA5A5_A5A5);
        tbl[1]  = mk(1, 0, 3'b000, 32'h0000_2002, 32'h0,        32'h1280_FF34, 1, 2, 1, 0, 0, 32'hFFFF_FF80, 4'b1111, 32'h0);
        tbl[2]  = mk(1, 0, 3'b100, 32'h0000_2002, 32'h0,        32'h1280_FF34, 3, 4, 3, 0, 0, 32'h0000_0080, 4'b1111, 32'h0);
        tbl[3]  = mk(1, 0, 3'b001, 32'h0000_2002, 32'h0,        32'h1280_FF34, 1, 2, 1, 0, 0, 32'h0000_1280, 4'b1111, 32'h0);
        tbl[4]  = mk(1, 0, 3'b101, 32'h0000_2000, 32'h0,        32'h1234_F00D, 2, 3, 2, 0, 0, 32'h0000_F00D, 4'b1111, 32'h0);
        tbl[5]  = mk(1, 0, 3'b001, 32'h0000_2000, 32'h0,        32'h0000_8001, 1, 2, 1, 0, 0, 32'hFFFF_8001, 4'b1111, 32'h0);
        tbl[6]  = mk(0, 1, 3'b001, 32'h0000_0006, 32'h1234_BEEF, 32'h0,        1, 2, 1, 0, 0, 32'hFFFF_8001, 4'b1100, 32'hBEEF_BEEF);
        tbl[7]  = mk(1, 0, 3'b010, 32'h0000_3001, 32'h0,        32'h0,        1, 1, 0, 1, 0, 32'hFFFF_8001, 4'b0000, 32'h0);
        tbl[8]  = mk(1, 0, 3'b011, 32'h0000_0020, 32'h0,        32'h0,        1, 1, 0, 0, 1, 32'hFFFF_8001, 4'b0000, 32'h0);
        tbl[9]  = mk(1, 1, 3'b100, 32'h0000_0000, 32'h0,        32'h0,        1, 1, 0, 0, 1, 32'hFFFF_8001, 4'b0000, 32'h0);
        tbl[10] = mk(0, 1, 3'b001, 32'h0000_0005, 32'h0,        32'h0,        1, 1, 0, 1, 0, 32'hFFFF_8001, 4'b0000, 32'h0);
        tbl[11] = mk(1, 0, 3'b111, 32'h0000_0003, 32'h0,        32'h0,        1, 1, 0, 0, 1, 32'hFFFF_8001, 4'b0000, 32'h0);
        tbl[12] = mk(1, 0, 3'b010, 32'h0000_0100, 32'h0,        32'h0,        0, 5, 4, 0, 1, 32'hFFFF_8001, 4'b1111, 32'h0);
        tbl[13] = mk(1, 0, 3'b010, 32'h0000_0100, 32'h0,        32'hCAFE_BABE, 4, 5, 4, 0, 0, 32'hCAFE_BABE, 4'b1111, 32'h0);
        tbl[14] = mk(0, 1, 3'b010, 32'h0000_0010, 32'h1122_3344, 32'h0,        1, 2, 1, 0, 0, 32'hCAFE_BABE, 4'b1111, 32'h1122_3344);
        tbl[15] = mk(1, 0, 3'b010, 32'h0000_0010, 32'h0,        32'h1122_3344, 1, 2, 1, 0, 0, 32'h1122_3344, 4'b1111, 32'h0);
        tbl[16] = mk(1, 1, 3'b000, 32'h0000_0001, 32'h0000_005A, 32'h0,        1, 2, 1, 0, 0, 32'h1122_3344, 4'b0010, 32'h5A5A_5A5A);
        tbl[17] = mk(1, 0, 3'b000, 32'h0000_0001, 32'h0,        32'h0000_7F00, 2, 3, 2, 0, 0, 32'h0000_007F, 4'b1111, 32'h0);
        tbl[18] = mk(0, 1, 3'b000, 32'h0000_0000, 32'hFFFF_FF3C, 32'h0,        1, 2, 1, 0, 0, 32'h0000_007F, 4'b0001, 32'h3C3C_3C3C);

        // Reset state.
        #2;
        chk("reset read_data", READ_DATA, 32'h0);
        chk("reset busywait", {31'd0, BUSYWAIT}, 32'd0);
        chk("reset mem_req", {31'd0, MEM_REQ}, 32'd0);
        chk("reset mem_be", {28'd0, MEM_BE}, 32'd0);
        chk("reset flags", {30'd0, MISALIGNED, ACCESS_FAULT}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 19; i++) begin
            run_vec(tbl[i], i);
        end

        // A stray ACK while idle must not touch READ_DATA or start anything.
        @(negedge CLK);
        MEM_ACK   = 1'b1;
        MEM_RDATA = 32'h5555_5555;
        #1;
        chk("stray ack busywait", {31'd0, BUSYWAIT}, 32'd0);
        @(negedge CLK);
        MEM_ACK   = 1'b0;
        MEM_RDATA = 32'hDEAD_BEEF;
        #1;
        chk("stray ack mem_req", {31'd0, MEM_REQ}, 32'd0);
        chk("stray ack read_data", READ_DATA, 32'h0000_007F);

        // Reset asserted while a load waits in ACCESS.
        @(negedge CLK);
        MEM_READ  = 1'b1;
        FUNCTION3 = 3'b010;
        ADDRESS   = 32'h0000_0040;
        begin
            int n;
            n = 0;
            while (!MEM_REQ && n < 10) begin
                @(negedge CLK);
                n++;
            end
        end
        #1;
        chk("midreset req_before", {31'd0, MEM_REQ}, 32'd1);
        MEM_READ = 1'b0;
        RESET    = 1'b1;
        #1;
        chk("midreset mem_req", {31'd0, MEM_REQ}, 32'd0);
        chk("midreset busywait", {31'd0, BUSYWAIT}, 32'd0);
        chk("midreset read_data", READ_DATA, 32'h0);
        chk("midreset mem_addr", {2'b00, MEM_ADDR}, 32'h0);
        chk("midreset mem_wdata", MEM_WDATA, 32'h0);
        chk("midreset we_be", {27'd0, MEM_WE, MEM_BE}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        // Controller must accept a fresh access after the abandoned one.
        run_vec(mk(1, 0, 3'b100, 32'h0000_0001, 32'h0, 32'h0000_AB00, 1, 2, 1, 0, 0,
                   32'h0000_00AB, 4'b1111, 32'h0), 19);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
